// File: rtl/nbit_down_counter.sv
// Loadable N-bit down-counter/timer with terminal-count pulse and optional auto-reload.
// Define DOWNCNT_PRESCALE_EN to decrement once every PRESCALE clocks instead of every clock.
module nbit_down_counter #(
    parameter int N        = 4,
    parameter int PRESCALE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [N-1:0] load_val,
    input  logic         auto_reload,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [N-1:0] count_n;
    logic [N-1:0] reload_q;
    logic [N-1:0] reload_n;
    logic         tc_n;
    logic         tick;

`ifdef DOWNCNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    // Prescaler only advances in an undisturbed RUN cycle; start/stop restart the phase.
    always_comb begin
        presc_n = '0;
        if (state == RUN && !stop && !start && !tick) begin
            presc_n = presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else begin
            presc <= presc_n;
        end
    end
`else
    // Every RUN cycle is a tick; PRESCALE only matters in the prescaled build.
    assign tick = (state == RUN) && (PRESCALE >= 1);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_q;
        tc_n     = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            reload_n = load_val;
            if (load_val == '0) begin
                count_n = '0;
                tc_n    = 1'b1;
                state_n = DONE;
            end else begin
                count_n = load_val;
                state_n = RUN;
            end
        end else if (tick) begin
            if (count > N'(1)) begin
                count_n = count - N'(1);
            end else begin
                // Terminal event: auto_reload is sampled here, not at start.
                tc_n = 1'b1;
                if (auto_reload) begin
                    count_n = reload_q;
                end else begin
                    count_n = '0;
                    state_n = DONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            reload_q <= reload_n;
            tc       <= tc_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
